// File: rtl/interp_mac_sequencer_if.sv
// Handshake and result bus of the time-shared fractional-delay interpolator.
// The sequencer takes the slave side; whoever feeds samples and consumes
// the phase-tagged result stream takes the master side.
interface interp_mac_sequencer_if #(
  parameter int DW = 14
);
  logic                 in_valid;
  logic signed [DW-1:0] xin;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic [1:0]           out_phase;
  logic                 busy;
  logic                 overrun;
  logic                 clr_overrun;

  modport slave (
    input  in_valid, xin, clr_overrun,
    output in_ready, out_valid, out_data, out_phase, busy, overrun
  );

  modport master (
    output in_valid, xin, clr_overrun,
    input  in_ready, out_valid, out_data, out_phase, busy, overrun
  );
endinterface

// File: rtl/interp_mac_sequencer.sv
// Time-shared 4-tap fractional-delay interpolator. Each accepted sample is
// shifted into a 4-deep history. The sequencer emits the integer-delay
// sample first, then runs one shared multiply-accumulate through the three
// FIR phases, emitting one phase-tagged result per phase.
module interp_mac_sequencer #(
  parameter int DW = 14,
  parameter int CW = 12,
  parameter int AW = 25
) (
  input logic                   clk,
  input logic                   rst,
  interp_mac_sequencer_if.slave bus
);
  localparam int SHIFT = 10;

  typedef enum logic [1:0] {IDLE, EMIT0, MAC, EMIT} stateT;

  stateT                r_state;
  logic signed [DW-1:0] r_hist [4];
  logic signed [AW-1:0] r_acc;
  logic [1:0]           r_p;
  logic [1:0]           r_t;
  logic                 r_outValid;
  logic signed [DW-1:0] r_outData;
  logic [1:0]           r_outPhase;
  logic                 r_overrun;

  logic                 w_accept;
  logic                 w_drop;
  logic signed [DW-1:0] w_tapSample;
  logic signed [CW-1:0] w_coef;
  logic signed [AW-1:0] w_tapExt;
  logic signed [AW-1:0] w_coefExt;
  logic signed [AW-1:0] w_prod;
  logic signed [AW-1:0] w_accNext;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_drop   = bus.in_valid && (r_state != IDLE);

  // Coefficient ROM; taps are ordered oldest (h0) to newest (h3).
  always_comb begin
    w_coef = '0;
    case ({r_p, r_t})
      4'b01_00: w_coef = CW'(-58);
      4'b01_01: w_coef = CW'(843);
      4'b01_10: w_coef = CW'(281);
      4'b01_11: w_coef = CW'(-42);
      4'b10_00: w_coef = CW'(-67);
      4'b10_01: w_coef = CW'(579);
      4'b10_10: w_coef = CW'(579);
      4'b10_11: w_coef = CW'(-67);
      4'b11_00: w_coef = CW'(-42);
      4'b11_01: w_coef = CW'(281);
      4'b11_10: w_coef = CW'(843);
      4'b11_11: w_coef = CW'(-58);
      default:  w_coef = '0;
    endcase
  end

  // The worst-case product fits in AW bits, so multiplying at accumulator
  // width after sign extension loses nothing.
  assign w_tapSample = r_hist[r_t];
  assign w_tapExt    = {{(AW-DW){w_tapSample[DW-1]}}, w_tapSample};
  assign w_coefExt   = {{(AW-CW){w_coef[CW-1]}}, w_coef};
  assign w_prod      = w_tapExt * w_coefExt;
  assign w_accNext   = r_acc + w_prod;

  // Sequencer: accept, emit the integer-delay tap, then MAC and emit each phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hist[0]  <= '0;
      r_hist[1]  <= '0;
      r_hist[2]  <= '0;
      r_hist[3]  <= '0;
      r_acc      <= '0;
      r_p        <= '0;
      r_t        <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outPhase <= '0;
    end else begin
      r_outValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_hist[0]  <= r_hist[1];
            r_hist[1]  <= r_hist[2];
            r_hist[2]  <= r_hist[3];
            r_hist[3]  <= bus.xin;
            r_outValid <= 1'b1;
            r_outData  <= r_hist[2];
            r_outPhase <= 2'd0;
            r_state    <= EMIT0;
          end
        end
        EMIT0: begin
          r_acc   <= '0;
          r_p     <= 2'd1;
          r_t     <= 2'd0;
          r_state <= MAC;
        end
        MAC: begin
          r_acc <= w_accNext;
          r_t   <= r_t + 2'd1;
          if (r_t == 2'd3) begin
            r_outValid <= 1'b1;
            r_outData  <= w_accNext[SHIFT+DW-1:SHIFT];
            r_outPhase <= r_p;
            r_state    <= EMIT;
          end
        end
        EMIT: begin
          if (r_p == 2'd3) begin
            r_state <= IDLE;
          end else begin
            r_p     <= r_p + 2'd1;
            r_acc   <= '0;
            r_t     <= 2'd0;
            r_state <= MAC;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky overrun flag; a new drop in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (bus.clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.out_phase = r_outPhase;
  assign bus.overrun   = r_overrun;
endmodule
